// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
// The initiator drives the master modport, the responder uses the slave modport.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory with byte-lane stores and a fixed response latency.
// Each access executes on the edge that enters RESP; the response is held until taken.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        latWrite_q;
    logic [31:0] latAddr_q;
    logic [31:0] latWdata_q;
    logic [3:0]  latWstrb_q;
    logic        rspValid_q;
    logic [31:0] rspRdata_q;
    logic        rspErr_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic             exWrite;
    logic [31:0]      exAddr;
    logic [31:0]      exWdata;
    logic [3:0]       exWstrb;
    logic             exErr;
    logic [IDX_W-1:0] exIdx;
    logic             enterResp;
    logic [31:0]      mergedWord_d;
    logic [31:0]      loadData_d;

    // With zero latency the access runs on the accept edge, so it must use the live request.
    always_comb begin
        exWrite = latWrite_q;
        exAddr  = latAddr_q;
        exWdata = latWdata_q;
        exWstrb = latWstrb_q;
        if (state_q == IDLE) begin
            exWrite = bus.req_write;
            exAddr  = bus.req_addr;
            exWdata = bus.req_wdata;
            exWstrb = bus.req_wstrb;
        end
    end

    always_comb begin
        exErr        = (exAddr[1:0] != 2'b00) || ({1'b0, exAddr} >= MEM_BYTES);
        exIdx        = exAddr[IDX_W+1:2];
        mergedWord_d = mem_q[exIdx];
        for (int lane = 0; lane < 4; lane++) begin
            if (exWstrb[lane]) begin
                mergedWord_d[8*lane +: 8] = exWdata[8*lane +: 8];
            end
        end
        loadData_d = (exWrite || exErr) ? 32'd0 : mem_q[exIdx];
        enterResp  = ((state_q == IDLE) && bus.req_valid && (LATENCY == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            latWrite_q <= 1'b0;
            latAddr_q  <= 32'd0;
            latWdata_q <= 32'd0;
            latWstrb_q <= 4'd0;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'd0;
            rspErr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        latWrite_q <= bus.req_write;
                        latAddr_q  <= bus.req_addr;
                        latWdata_q <= bus.req_wdata;
                        latWstrb_q <= bus.req_wstrb;
                        if (LATENCY == 0) begin
                            state_q    <= RESP;
                            rspValid_q <= 1'b1;
                            rspRdata_q <= loadData_d;
                            rspErr_q   <= exErr;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspRdata_q <= loadData_d;
                        rspErr_q   <= exErr;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q    <= IDLE;
                        rspValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rspValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Stores commit only on the execute edge, so a reset before then drops them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
                mem_q[w] <= 32'd0;
            end
        end else if (enterResp && exWrite && !exErr) begin
            mem_q[exIdx] <= mergedWord_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.rsp_err   = rspErr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with LATENCY=2 and one with LATENCY=0,
// driven through a shared stimulus path selected by 'sel' and checked against a word-array model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int          sel;
    logic        tValid;
    logic        tWrite;
    logic [31:0] tAddr;
    logic [31:0] tWdata;
    logic [3:0]  tWstrb;
    logic        tRspReady;

    assign bus0.req_valid = tValid && (sel == 0);
    assign bus0.req_write = tWrite;
    assign bus0.req_addr  = tAddr;
    assign bus0.req_wdata = tWdata;
    assign bus0.req_wstrb = tWstrb;
    assign bus0.rsp_ready = tRspReady && (sel == 0);
    assign bus1.req_valid = tValid && (sel == 1);
    assign bus1.req_write = tWrite;
    assign bus1.req_addr  = tAddr;
    assign bus1.req_wdata = tWdata;
    assign bus1.req_wstrb = tWstrb;
    assign bus1.rsp_ready = tRspReady && (sel == 1);

    logic        oReady;
    logic        oValid;
    logic [31:0] oRdata;
    logic        oErr;

    always_comb begin
        oReady = (sel == 1) ? bus1.req_ready : bus0.req_ready;
        oValid = (sel == 1) ? bus1.rsp_valid : bus0.rsp_valid;
        oRdata = (sel == 1) ? bus1.rsp_rdata : bus0.rsp_rdata;
        oErr   = (sel == 1) ? bus1.rsp_err   : bus0.rsp_err;
    end

    int checks = 0;
    int passes = 0;
    time acceptTime;

    // Behavioural model: one plain word array per instance, byte address in, word out.
    logic [31:0] modelMem [2][256];

    function automatic void modelClear();
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 256; w++)
                modelMem[s][w] = 32'd0;
    endfunction

    function automatic void modelAccess(input int s, input logic w, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] ws,
                                        output logic [31:0] rd, output logic er);
        er = (a % 4 != 0) || (a >= 32'd1024);
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) modelMem[s][a[9:2]][8*i +: 8] = wd[8*i +: 8];
            end else begin
                rd = modelMem[s][a[9:2]];
            end
        end
    endfunction

    function automatic int latFor(input int s);
        return (s == 1) ? 0 : 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic scramble();
        tWrite = 1'($urandom);
        tAddr  = $urandom;
        tWdata = $urandom;
        tWstrb = 4'($urandom);
    endtask

    // One full transaction; starts and ends just after a falling edge.
    task automatic applyStimulus(input int s, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws, input int hold,
                                 input logic [31:0] expRd, input logic expErr);
        int cyc;
        logic seen;
        logic stableOk;
        logic [31:0] firstRd;
        logic firstErr;
        sel       = s;
        tValid    = 1'b1;
        tWrite    = w;
        tAddr     = a;
        tWdata    = wd;
        tWstrb    = ws;
        tRspReady = 1'b0;
        #1;
        checkOutput("req_ready_idle", 32'(oReady), 32'd1);
        @(posedge clk);
        acceptTime = $time;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (oValid) seen = 1'b1;
            scramble();
        end
        checkOutput("rsp_latency", 32'(cyc), 32'(latFor(s) + 1));
        if (!seen) begin
            tValid = 1'b0;
            return;
        end
        checkOutput("rsp_rdata", oRdata, expRd);
        checkOutput("rsp_err", 32'(oErr), 32'(expErr));
        checkOutput("req_ready_busy", 32'(oReady), 32'd0);
        firstRd  = oRdata;
        firstErr = oErr;
        stableOk = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!oValid || oRdata !== firstRd || oErr !== firstErr || oReady) stableOk = 1'b0;
            scramble();
        end
        if (hold > 0) checkOutput("resp_hold_stable", 32'(stableOk), 32'd1);
        tValid    = 1'b0;
        tRspReady = 1'b1;
        @(negedge clk);
        tRspReady = 1'b0;
        checkOutput("req_ready_after_resp", 32'(oReady), 32'd1);
        checkOutput("rsp_valid_after_resp", 32'(oValid), 32'd0);
    endtask

    typedef struct {
        int          s;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          hold;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        time         t0;
        int          cyc;
        logic        quiet;

        vecs.push_back('{0, 1'b1, 32'h8,        32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h8,        32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h10,       32'h11223344, 4'hF, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 32'h10,       32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h10,       32'h0,        4'h3, 5, 32'h11BB33DD, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h6,        32'h0,        4'h0, 0, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b1, 32'h0,        32'h12345678, 4'hF, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b1, 32'h400,      32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 32'h0,        32'h0,        4'h0, 0, 32'h12345678, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h0,        32'h99999999, 4'h0, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h0,        32'h0,        4'h0, 2, 32'h12345678, 1'b0});
        vecs.push_back('{0, 1'b1, 32'h3FC,      32'hCAFEF00D, 4'hF, 0, 32'h0,        1'b0});
        vecs.push_back('{0, 1'b0, 32'h3FC,      32'h0,        4'h0, 0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{0, 1'b0, 32'h3FD,      32'h0,        4'h0, 0, 32'h0,        1'b1});
        vecs.push_back('{0, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 0, 32'h0,        1'b1});
        vecs.push_back('{1, 1'b1, 32'h8,        32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b1, 32'h8,        32'h00770000, 4'h4, 0, 32'h0,        1'b0});
        vecs.push_back('{1, 1'b0, 32'h8,        32'h0,        4'hF, 3, 32'hDE77BEEF, 1'b0});
        vecs.push_back('{1, 1'b0, 32'h401,      32'h0,        4'h0, 0, 32'h0,        1'b1});

        sel = 0; tValid = 1'b0; tWrite = 1'b0; tAddr = '0; tWdata = '0; tWstrb = '0; tRspReady = 1'b0;
        rst = 1'b1;
        modelClear();
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", 32'(oReady), 32'd0);
        checkOutput("reset_rsp_valid", 32'(oValid), 32'd0);
        checkOutput("reset_rsp_rdata", oRdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(oErr), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(oReady), 32'd1);
        @(negedge clk);

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            modelAccess(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].ws, rd, er);
            applyStimulus(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].ws,
                          vecs[i].hold, vecs[i].expRd, vecs[i].expErr);
        end

        $display("[TB] back-to-back spacing");
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDE77BEEF, 1'b0);
        t0 = acceptTime;
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDE77BEEF, 1'b0);
        checkOutput("lat0_spacing", 32'(acceptTime - t0), 32'd20);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
        t0 = acceptTime;
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0);
        checkOutput("lat2_spacing", 32'(acceptTime - t0), 32'd40);

        $display("[TB] reset while a load response is pending");
        sel = 0; tValid = 1'b1; tWrite = 1'b0; tAddr = 32'h8; tWstrb = 4'h0;
        @(posedge clk);
        cyc = 0;
        while (!oValid && cyc < 20) begin
            @(negedge clk);
            tValid = 1'b0;
            cyc++;
        end
        checkOutput("resp_before_reset", oRdata, 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        checkOutput("reset_in_resp_valid", 32'(oValid), 32'd0);
        checkOutput("reset_in_resp_rdata", oRdata, 32'd0);
        modelClear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset while a store waits");
        sel = 0; tValid = 1'b1; tWrite = 1'b1; tAddr = 32'h0; tWdata = 32'h5; tWstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        tValid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset_in_wait_valid", 32'(oValid), 32'd0);
        checkOutput("reset_in_wait_rdata", oRdata, 32'd0);
        checkOutput("reset_in_wait_err", 32'(oErr), 32'd0);
        checkOutput("reset_in_wait_ready", 32'(oReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_abort", 32'(oReady), 32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (oValid) quiet = 1'b1 & 1'b0;
        end
        checkOutput("no_resp_after_abort", 32'(quiet), 32'd1);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0, 1'b0);

        $display("[TB] randomized traffic against model");
        for (int n = 0; n < 80; n++) begin
            int s;
            logic w;
            logic [31:0] wd;
            logic [3:0] ws;
            s  = int'($urandom_range(0, 1));
            w  = 1'($urandom);
            wd = $urandom;
            ws = 4'($urandom);
            case ($urandom_range(0, 9))
                0:       a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
                1:       a = 32'h400 + ($urandom_range(0, 1000) << 2);
                default: a = $urandom_range(0, 15) << 2;
            endcase
            modelAccess(s, w, a, wd, ws, rd, er);
            applyStimulus(s, w, a, wd, ws, int'($urandom_range(0, 3)), rd, er);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
